// File: rtl/conv_loop_ctrl_if.sv
// conv_loop_ctrl_if: job control, FIFO/stall handshakes, datapath strobes and
// loop indices between the convolution loop controller and its neighbours.
// Optional stall counter port: CONV_LOOP_CTRL_STALL_CNT_EN.
interface conv_loop_ctrl_if #(
    parameter int IDX_W = 4
`ifdef CONV_LOOP_CTRL_STALL_CNT_EN
   ,parameter int PERF_W = 16
`endif
);
    logic             start;
    logic             mode;
    logic [IDX_W-1:0] cfg_filt;
    logic [IDX_W-1:0] cfg_stride;
    logic [IDX_W-1:0] cfg_win;
    logic             in_empty;
    logic             out_stall;
    logic             is_zero;
    logic [IDX_W-1:0] c0;
    logic [IDX_W-1:0] c1;
    logic [IDX_W-1:0] c2;
    logic             in_rd;
    logic             mac_en;
    logic             acc_clr;
    logic             out_ld;
    logic             busy;
    logic             done;
`ifdef CONV_LOOP_CTRL_STALL_CNT_EN
    logic [PERF_W-1:0] stall_cnt;

    modport master (
        output start, mode, cfg_filt, cfg_stride, cfg_win, in_empty, out_stall, is_zero,
        input  c0, c1, c2, in_rd, mac_en, acc_clr, out_ld, busy, done, stall_cnt
    );

    modport slave (
        input  start, mode, cfg_filt, cfg_stride, cfg_win, in_empty, out_stall, is_zero,
        output c0, c1, c2, in_rd, mac_en, acc_clr, out_ld, busy, done, stall_cnt
    );
`else
    modport master (
        output start, mode, cfg_filt, cfg_stride, cfg_win, in_empty, out_stall, is_zero,
        input  c0, c1, c2, in_rd, mac_en, acc_clr, out_ld, busy, done
    );

    modport slave (
        input  start, mode, cfg_filt, cfg_stride, cfg_win, in_empty, out_stall, is_zero,
        output c0, c1, c2, in_rd, mac_en, acc_clr, out_ld, busy, done
    );
`endif
endinterface

// File: rtl/conv_loop_ctrl.sv
// conv_loop_ctrl: three nested loop counters (filter element c0, stride phase
// c1, window c2) for the streaming convolution datapath. Loop order and bounds
// are latched per job; the controller pops the input FIFO, gates the MAC and
// strobes accumulator clear / output load.
// Optional feature macro: CONV_LOOP_CTRL_STALL_CNT_EN adds a saturating
// counter of RUN cycles lost to empty input or output back-pressure.
module conv_loop_ctrl #(
    parameter int IDX_W = 4
`ifdef CONV_LOOP_CTRL_STALL_CNT_EN
   ,parameter int PERF_W = 16
`endif
) (
    input  logic           clk,
    input  logic           rst_n,
    conv_loop_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_INIT = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [IDX_W-1:0] ONE = {{(IDX_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic             mode_q, mode_d;
    logic [IDX_W-1:0] filt_q, filt_d;
    logic [IDX_W-1:0] stride_q, stride_d;
    logic [IDX_W-1:0] win_q, win_d;
    logic [IDX_W-1:0] c0_q, c0_d;
    logic [IDX_W-1:0] c1_q, c1_d;
    logic [IDX_W-1:0] c2_q, c2_d;
    logic             out_ld_q, out_ld_d;

    logic step;
    logic wrap0, wrap1, wrap2;
    logic last;

    // A step happens only in RUN with data available and no back-pressure.
    assign step  = (state_q == S_RUN) & ~bus.in_empty & ~bus.out_stall;
    assign wrap0 = (c0_q == filt_q - ONE);
    assign wrap1 = (c1_q == stride_q - ONE);
    assign wrap2 = (c2_q == win_q - ONE);
    assign last  = wrap0 & wrap1 & wrap2;

    assign bus.c0     = c0_q;
    assign bus.c1     = c1_q;
    assign bus.c2     = c2_q;
    assign bus.out_ld = out_ld_q;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // FSM next state and the combinational strobes.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        bus.in_rd   = 1'b0;
        bus.mac_en  = 1'b0;
        bus.acc_clr = out_ld_q;
        bus.busy    = 1'b0;
        bus.done    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) state_d = S_INIT;
            end
            S_INIT: begin
                state_d     = S_RUN;
                bus.acc_clr = 1'b1;
                bus.busy    = 1'b1;
            end
            S_RUN: begin
                bus.busy   = 1'b1;
                bus.in_rd  = step;
                bus.mac_en = step & ~bus.is_zero;
                if (step && last) state_d = S_DONE;
            end
            S_DONE: begin
                state_d  = S_IDLE;
                bus.done = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Per-job configuration capture and loop counter advance.
    always_comb begin
        mode_d   = mode_q;
        filt_d   = filt_q;
        stride_d = stride_q;
        win_d    = win_q;
        c0_d     = c0_q;
        c1_d     = c1_q;
        c2_d     = c2_q;
        out_ld_d = step & wrap0;
        if (state_q == S_INIT) begin
            // A zero bound would never wrap; treat it as a single iteration.
            mode_d   = bus.mode;
            filt_d   = (bus.cfg_filt   == '0) ? ONE : bus.cfg_filt;
            stride_d = (bus.cfg_stride == '0) ? ONE : bus.cfg_stride;
            win_d    = (bus.cfg_win    == '0) ? ONE : bus.cfg_win;
            c0_d     = '0;
            c1_d     = '0;
            c2_d     = '0;
        end else if (step) begin
            c0_d = wrap0 ? '0 : c0_q + ONE;
            if (!mode_q) begin
                // c1 middle, c2 outer
                if (wrap0)          c1_d = wrap1 ? '0 : c1_q + ONE;
                if (wrap0 && wrap1) c2_d = wrap2 ? '0 : c2_q + ONE;
            end else begin
                // c2 middle, c1 outer
                if (wrap0)          c2_d = wrap2 ? '0 : c2_q + ONE;
                if (wrap0 && wrap2) c1_d = wrap1 ? '0 : c1_q + ONE;
            end
        end
    end

    // Configuration, counter and output-load registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q   <= 1'b0;
            filt_q   <= ONE;
            stride_q <= ONE;
            win_q    <= ONE;
            c0_q     <= '0;
            c1_q     <= '0;
            c2_q     <= '0;
            out_ld_q <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            filt_q   <= filt_d;
            stride_q <= stride_d;
            win_q    <= win_d;
            c0_q     <= c0_d;
            c1_q     <= c1_d;
            c2_q     <= c2_d;
            out_ld_q <= out_ld_d;
        end
    end

`ifdef CONV_LOOP_CTRL_STALL_CNT_EN
    localparam logic [PERF_W-1:0] PERF_ONE = {{(PERF_W-1){1'b0}}, 1'b1};

    logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;

    assign bus.stall_cnt = stall_cnt_q;

    // Lost RUN cycles: cleared when a job starts, saturating, held after DONE.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (state_q == S_INIT)
            stall_cnt_d = '0;
        else if ((state_q == S_RUN) && !step && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + PERF_ONE;
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_cnt_q <= '0;
        else        stall_cnt_q <= stall_cnt_d;
    end
`endif

endmodule

// File: tb/tb_conv_loop_ctrl.sv
// tb_conv_loop_ctrl: directed and randomized jobs against a queue-based model
// of the loop controller. The model expands each job into its ordered list of
// index tuples and consumes one entry per step.
`timescale 1ns/1ps
module tb_conv_loop_ctrl;

    localparam int IDX_W = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    conv_loop_ctrl_if #(
        .IDX_W(IDX_W)
`ifdef CONV_LOOP_CTRL_STALL_CNT_EN
       ,.PERF_W(16)
`endif
    ) bus ();

    conv_loop_ctrl #(
        .IDX_W(IDX_W)
`ifdef CONV_LOOP_CTRL_STALL_CNT_EN
       ,.PERF_W(16)
`endif
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum int {M_IDLE, M_INIT, M_RUN, M_DONE} mphase_t;

    mphase_t          m_ph = M_IDLE;
    logic [IDX_W-1:0] q0[$];
    logic [IDX_W-1:0] q1[$];
    logic [IDX_W-1:0] q2[$];
    int               m_filt = 1;
    logic             m_ld = 1'b0;
    logic [15:0]      m_stall = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ph = M_IDLE;
            q0.delete(); q1.delete(); q2.delete();
            m_ld = 1'b0;
            m_stall = '0;
        end else begin
            case (m_ph)
                M_IDLE: begin
                    m_ld = 1'b0;
                    if (bus.start) m_ph = M_INIT;
                end
                M_INIT: begin
                    int fs, ss, ws, outer, middle;
                    fs = (bus.cfg_filt   == 0) ? 1 : int'(bus.cfg_filt);
                    ss = (bus.cfg_stride == 0) ? 1 : int'(bus.cfg_stride);
                    ws = (bus.cfg_win    == 0) ? 1 : int'(bus.cfg_win);
                    m_filt = fs;
                    outer  = bus.mode ? ss : ws;
                    middle = bus.mode ? ws : ss;
                    q0.delete(); q1.delete(); q2.delete();
                    for (int a = 0; a < outer; a++)
                        for (int b = 0; b < middle; b++)
                            for (int c = 0; c < fs; c++) begin
                                q0.push_back(4'(c));
                                if (!bus.mode) begin
                                    q1.push_back(4'(b)); q2.push_back(4'(a));
                                end else begin
                                    q1.push_back(4'(a)); q2.push_back(4'(b));
                                end
                            end
                    m_stall = '0;
                    m_ld = 1'b0;
                    m_ph = M_RUN;
                end
                M_RUN: begin
                    if (!bus.in_empty && !bus.out_stall) begin
                        m_ld = (int'(q0[0]) == m_filt - 1);
                        void'(q0.pop_front()); void'(q1.pop_front()); void'(q2.pop_front());
                        if (q0.size() == 0) m_ph = M_DONE;
                    end else begin
                        m_ld = 1'b0;
                        if (m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
                    end
                end
                default: begin
                    m_ld = 1'b0;
                    m_ph = M_IDLE;
                end
            endcase
        end
    end

    // ---------------- per-cycle compare ----------------
    logic             e_run, e_step;
    logic [IDX_W-1:0] e0, e1, e2;

    always @(negedge clk) begin
        e_run  = (m_ph == M_RUN);
        e_step = e_run && !bus.in_empty && !bus.out_stall;
        e0 = e_run ? q0[0] : '0;
        e1 = e_run ? q1[0] : '0;
        e2 = e_run ? q2[0] : '0;
        check("c0", bus.c0, e0);
        check("c1", bus.c1, e1);
        check("c2", bus.c2, e2);
        check("in_rd", bus.in_rd, e_step);
        check("mac_en", bus.mac_en, e_step && !bus.is_zero);
        check("out_ld", bus.out_ld, m_ld);
        check("acc_clr", bus.acc_clr, m_ld || (m_ph == M_INIT));
        check("busy", bus.busy, (m_ph == M_INIT) || e_run);
        check("done", bus.done, m_ph == M_DONE);
`ifdef CONV_LOOP_CTRL_STALL_CNT_EN
        check("stall_cnt", bus.stall_cnt, m_stall);
`endif
    end

    // ---------------- job driver ----------------
    // Called right after a clock edge in IDLE; that edge's following edge is
    // "edge 0", so cycle 1 is INIT and cyc numbers match the job timeline.
    task automatic job(input logic md, input int f, input int s, input int w,
                       input logic [31:0] stall_m, input logic [31:0] empty_m,
                       input bit rnd, input bit hold_start,
                       output int done_cyc, output int n_rd, output logic [47:0] trace,
                       output logic [31:0] ld_m, output logic [31:0] busy_m,
                       output logic [15:0] sc);
        int cyc;
        bit fin;
        done_cyc = -1; n_rd = 0; trace = '0; ld_m = '0; busy_m = '0; sc = '0; fin = 0;
        bus.start = 1'b1;
        bus.mode = md;
        bus.cfg_filt = 4'(f); bus.cfg_stride = 4'(s); bus.cfg_win = 4'(w);
        @(posedge clk);
        cyc = 1;
        while (!fin && cyc < 20000) begin
            #1;
            bus.start = hold_start;
            if (cyc >= 2) begin
                bus.mode = 1'($urandom);
                bus.cfg_filt = 4'($urandom); bus.cfg_stride = 4'($urandom); bus.cfg_win = 4'($urandom);
            end
            bus.out_stall = (cyc < 32 && stall_m[cyc]) || (rnd && $urandom_range(0, 3) == 0);
            bus.in_empty  = (cyc < 32 && empty_m[cyc]) || (rnd && $urandom_range(0, 4) == 0);
            bus.is_zero   = rnd ? 1'($urandom) : n_rd[0];
            @(negedge clk);
            if (bus.in_rd) begin
                n_rd++;
                trace = {trace[39:0], bus.c1, bus.c2};
            end
            if (cyc < 32) begin
                ld_m[cyc] = bus.out_ld;
                busy_m[cyc] = bus.busy;
            end
            if (bus.done) begin
                done_cyc = cyc;
                fin = 1;
`ifdef CONV_LOOP_CTRL_STALL_CNT_EN
                sc = bus.stall_cnt;
`endif
            end
            @(posedge clk);
            cyc++;
        end
        if (!fin) check("job_timeout", 48'(cyc), 48'(0));
        #1;
        bus.start = 1'b0; bus.out_stall = 1'b0; bus.in_empty = 1'b0; bus.is_zero = 1'b0;
    endtask

    int          d_cyc, nrd;
    logic [47:0] tr;
    logic [31:0] ldm, bsm;
    logic [15:0] scv;

    initial begin
        bus.start = 1'b0; bus.mode = 1'b0;
        bus.cfg_filt = '0; bus.cfg_stride = '0; bus.cfg_win = '0;
        bus.in_empty = 1'b0; bus.out_stall = 1'b0; bus.is_zero = 1'b0;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        check("reset_busy", bus.busy, 0);
        check("reset_c0", bus.c0, 0);

        // Nominal job: filt=3 stride=1 win=2 mode 0
        job(1'b0, 3, 1, 2, 32'h0, 32'h0, 0, 0, d_cyc, nrd, tr, ldm, bsm, scv);
        check("nom_done_cyc", 48'(d_cyc), 48'd8);
        check("nom_steps", 48'(nrd), 48'd6);
        check("nom_out_ld_cycles", 48'(ldm), 48'h120);
        check("nom_busy_cycles", 48'(bsm), 48'hFE);

        // Loop order
        job(1'b0, 1, 2, 3, 32'h0, 32'h0, 0, 0, d_cyc, nrd, tr, ldm, bsm, scv);
        check("order_m0_trace", tr, 48'h00_10_01_11_02_12);
        check("order_m0_steps", 48'(nrd), 48'd6);
        job(1'b1, 1, 2, 3, 32'h0, 32'h0, 0, 0, d_cyc, nrd, tr, ldm, bsm, scv);
        check("order_m1_trace", tr, 48'h00_01_02_10_11_12);
        check("order_m1_steps", 48'(nrd), 48'd6);

        // Stall and empty: out_stall cycles 3-4, in_empty cycle 6
        job(1'b0, 3, 1, 2, 32'h18, 32'h40, 0, 0, d_cyc, nrd, tr, ldm, bsm, scv);
        check("stall_done_cyc", 48'(d_cyc), 48'd11);
        check("stall_steps", 48'(nrd), 48'd6);
        check("stall_out_ld_cycles", 48'(ldm), 48'h900);
`ifdef CONV_LOOP_CTRL_STALL_CNT_EN
        check("stall_cnt_final", 48'(scv), 48'd3);
`endif

        // Zero bound on filt behaves as 1
        job(1'b0, 0, 2, 2, 32'h0, 32'h0, 0, 0, d_cyc, nrd, tr, ldm, bsm, scv);
        check("zero_filt_steps", 48'(nrd), 48'd4);
        check("zero_filt_out_ld", 48'(ldm), 48'h78);
        check("zero_filt_done_cyc", 48'(d_cyc), 48'd6);

        // start held high throughout the job
        job(1'b0, 3, 1, 2, 32'h0, 32'h0, 0, 1, d_cyc, nrd, tr, ldm, bsm, scv);
        check("hold_done_cyc", 48'(d_cyc), 48'd8);
        check("hold_busy_cycles", 48'(bsm), 48'hFE);

        // Reset in the middle of RUN
        begin
            int seen_done;
            bus.start = 1'b1; bus.mode = 1'b0;
            bus.cfg_filt = 4'd4; bus.cfg_stride = 4'd3; bus.cfg_win = 4'd2;
            repeat (5) @(posedge clk);
            #3 rst_n = 1'b0;
            #1;
            check("rst_mid_busy", bus.busy, 0);
            check("rst_mid_in_rd", bus.in_rd, 0);
            check("rst_mid_c0", bus.c0, 0);
            check("rst_mid_acc_clr", bus.acc_clr, 0);
            bus.start = 1'b0;
            @(negedge clk); #2 rst_n = 1'b1;
            seen_done = 0;
            repeat (20) begin
                @(negedge clk);
                if (bus.done || bus.busy) seen_done++;
            end
            check("rst_mid_no_done", 48'(seen_done), 48'd0);
            @(posedge clk); #1;
        end

        // Randomized jobs with random stalls / empties / zero operands
        for (int j = 0; j < 30; j++) begin
            logic md;
            int f, s, w, exp_steps;
            md = 1'($urandom);
            f = $urandom_range(0, 5); s = $urandom_range(0, 5); w = $urandom_range(0, 5);
            if (j == 28) begin f = 15; s = 2; w = 1; end
            if (j == 29) begin f = 2; s = 15; w = 15; end
            exp_steps = (f == 0 ? 1 : f) * (s == 0 ? 1 : s) * (w == 0 ? 1 : w);
            job(md, f, s, w, 32'h0, 32'h0, 1, 0, d_cyc, nrd, tr, ldm, bsm, scv);
            check("rand_steps", 48'(nrd), 48'(exp_steps));
        end

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/conv_loop_ctrl.md
# conv_loop_ctrl

Parametrised loop controller for the streaming convolution datapath. It sequences three nested index counters: filter element, stride phase and window. It pops the input FIFO, enables the MAC and issues accumulator clear and output load strobes. Configurable loop order and loop bounds are latched per job. It sits between the input FIFO/output buffer pair and the MAC/accumulator datapath, and supersedes the fixed-order controller.

## Interface
- `IDX_W`, 4: width of each loop counter and its bound.
- `PERF_W`, 16: width of the stall counter (only with the configuration macro).
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: job request, sampled in IDLE only.
- `mode` in 1: loop order. 0 = c0 inner, c1 middle, c2 outer. 1 = c0 inner, c2 middle, c1 outer.
- `cfg_filt` in IDX_W: filter length, bound of c0.
- `cfg_stride` in IDX_W: stride, bound of c1.
- `cfg_win` in IDX_W: window count, bound of c2.
- `in_empty` in 1: input FIFO empty.
- `out_stall` in 1: downstream back-pressure.
- `is_zero` in 1: current operand is zero (MAC skip).
- `c0`, `c1`, `c2` out IDX_W: current indices, for address generation.
- `in_rd` out 1: FIFO pop.
- `mac_en` out 1: MAC enable.
- `acc_clr` out 1: accumulator clear.
- `out_ld` out 1: output register load.
- `busy` out 1: job in progress.
- `done` out 1: one-cycle completion pulse.

## Operation
- States: IDLE, INIT, RUN, DONE.
  - IDLE → INIT on `start`.
  - INIT → RUN unconditionally (one cycle).
  - RUN → DONE after the final step.
  - DONE → IDLE unconditionally (one cycle).
- INIT behaviour:
  - Latches `mode` and the three bounds.
  - A bound of 0 is latched as 1.
  - Clears c0, c1, c2.
- `step` = (state == RUN) & ~`in_empty` & ~`out_stall`. It is an internal signal and advances only on step.
- Counter rules:
  - c0 increments every step and wraps from bound−1 to 0.
  - mode 0: c1 increments when c0 wraps; c2 increments when c0 and c1 both wrap.
  - mode 1: c2 increments when c0 wraps; c1 increments when c0 and c2 both wrap.
- Final step: all three counters are at bound−1 during a step. The counters return to 0 and the state goes to DONE.
- Outputs:
  - `in_rd` = step.
  - `mac_en` = step & ~`is_zero`.
  - `out_ld` is a register, set to step & (c0 == filt−1).
  - `acc_clr` = `out_ld` | (state == INIT).
  - `busy` = INIT or RUN.
  - `done` = (state == DONE).
- `start` in INIT, RUN or DONE is ignored. Config inputs are ignored outside INIT.
- Total steps per job = filt × stride × win, independent of mode. Mode changes only the index visiting order.

## Timing
- Reset (asynchronous, `rst_n` low):
  - State goes to IDLE; c0, c1, c2 = 0; `out_ld` = 0.
  - All outputs are 0.
  - Applies mid-job: the job is abandoned and no `done` is issued.
- Latencies:
  - `start` sampled at edge N → INIT in cycle N+1.
  - First possible step is in cycle N+2.
  - `out_ld` and its `acc_clr` are asserted the cycle after the window's last step. This holds even if the next cycle stalls.
  - `done` is asserted the cycle after the final step, coincident with the last `out_ld`.
- `in_empty` and `out_stall` act combinationally on `in_rd` and `mac_en` in the same cycle.
- Stalls freeze the counters with no loss of position. Simultaneous `in_empty` and `out_stall` behave as a single stall.
- Bounds of 2^IDX_W−1 are legal. Counters never exceed bound−1.

## Configuration
- Macro: `CONV_LOOP_CTRL_STALL_CNT_EN`.
- When defined:
  - Adds output `stall_cnt` [PERF_W-1:0].
  - Cleared in INIT.
  - Increments on each RUN cycle without a step.
  - Saturates at all-ones and holds its value after DONE.
  - Reset value is 0.
- When undefined: the port and counter are absent; the remaining behaviour is identical.

## Test plan
- **Nominal job:** filt=3, stride=1, win=2, mode=0, no stalls, `start` at edge 0 → INIT cycle 1; `in_rd` high cycles 2–7; `out_ld` and `acc_clr` in cycles 5 and 8; `done` in cycle 8; `busy` in cycles 1–7.
- **Loop order:** filt=1, stride=2, win=3. mode 0 → (c1,c2) sequence 00,10,01,11,02,12. mode 1 → 00,01,02,10,11,12. Both jobs take 6 steps.
- **Stall and empty:** nominal job with `out_stall` high cycles 3–4 and `in_empty` high cycle 6 → counters frozen; `done` delayed 3 cycles to cycle 11; with the macro, `stall_cnt` = 3.
- **Zero skip and zero bounds:** `is_zero`=1 on alternate steps → `mac_en` low on those steps while `in_rd` stays high. cfg_filt=0 → behaves as filt=1.
- **Reset mid-job and ignored start:** `rst_n` low during RUN → all outputs 0 immediately, no `done`. `start` held high through RUN → no restart until IDLE.
